// File: rtl/vrf_write_scheduler_if.sv
// Writeback request bus shared by all PORT_NUM ports.
//
// Handshake: a request on port p transfers on a rising clk edge where
// wr_valid[p] && wr_ready[p]. While wr_valid[p] is high and wr_ready[p] is
// low, the requester holds wr_addr[p]/wr_data[p] stable. wr_ready never
// depends combinationally on wr_valid.
//
// Signals:
//   wr_valid [PORT_NUM]              request valid per port  (master -> slave)
//   wr_ready [PORT_NUM]              port FIFO has room      (slave -> master)
//   wr_addr  [PORT_NUM][ADDR_WIDTH]  vreg address per port   (master -> slave)
//   wr_data  [PORT_NUM][DATA_WIDTH]  write data per port     (master -> slave)
interface vrf_write_scheduler_if #(
  parameter int PORT_NUM   = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 128
) ();
  logic [PORT_NUM-1:0]                 wr_valid;
  logic [PORT_NUM-1:0]                 wr_ready;
  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0] wr_addr;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vrf_write_scheduler.sv
// Schedules writeback requests from PORT_NUM ports onto the four
// single-write-port VRF banks (2x2 X/Y banking).
//
// Each port owns a 2-entry request FIFO. Every bank runs a round-robin
// arbiter over the FIFO heads that target it and drives a registered write
// the cycle after the grant.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr           request bus (slave side): wr_valid/wr_ready/wr_addr/wr_data
//   bank_we      [4]             bank write enable, b = {addr[MSB], addr[0]}
//   bank_addr    [4][ROW_WIDTH]  row = addr[ADDR_WIDTH-2:1]
//   bank_wdata   [4][DATA_WIDTH] bank write data
//   bank_src     [4][PORT_NUM]   one-hot source port, 0 when bank_we is 0
//   busy         any FIFO non-empty or any bank write in flight
module vrf_write_scheduler #(
  parameter int PORT_NUM   = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_WIDTH  = ADDR_WIDTH - 2,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  vrf_write_scheduler_if.slave                 wr,
  output logic [3:0]                           bank_we,
  output logic [3:0][ROW_WIDTH-1:0]            bank_addr,
  output logic [3:0][DATA_WIDTH-1:0]           bank_wdata,
  output logic [3:0][PORT_NUM-1:0]             bank_src,
  output logic                                 busy
);
  localparam int PTR_W = $clog2(PORT_NUM);

  // Per-port FIFO storage. Payload is not reset; validity lives in cnt.
  logic [ADDR_WIDTH-1:0] mem_addr [PORT_NUM][2];
  logic [DATA_WIDTH-1:0] mem_data [PORT_NUM][2];
  logic [PORT_NUM-1:0]       rd_ptr;
  logic [PORT_NUM-1:0]       wr_ptr;
  logic [PORT_NUM-1:0][1:0]  cnt;
  logic [3:0][PTR_W-1:0]     rr_ptr;

  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0] head_addr;
  logic [PORT_NUM-1:0][DATA_WIDTH-1:0] head_data;
  logic [PORT_NUM-1:0]                 ready;
  logic [PORT_NUM-1:0]                 push;
  logic [PORT_NUM-1:0]                 pop;
  logic [3:0][PORT_NUM-1:0]            cand;
  logic [3:0][PORT_NUM-1:0]            gnt;
  logic [3:0]                          bank_hit;
  logic [3:0][PTR_W-1:0]               rr_nxt;
  logic [3:0][ROW_WIDTH-1:0]           win_row;
  logic [3:0][DATA_WIDTH-1:0]          win_data;
  int d, best_d, best_p, nxt;

  // Ready comes from registered occupancy only, so a pop this cycle frees
  // space from the next cycle on.
  always_comb begin
    head_addr = '0;
    head_data = '0;
    ready     = '0;
    push      = '0;
    cand      = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      head_addr[p] = mem_addr[p][rd_ptr[p]];
      head_data[p] = mem_data[p][rd_ptr[p]];
      ready[p]     = int'(cnt[p]) < FIFO_DEPTH;
      push[p]      = wr.wr_valid[p] & ready[p];
      for (int b = 0; b < 4; b++) begin
        cand[b][p] = (cnt[p] != 2'd0) &&
                     ({head_addr[p][ADDR_WIDTH-1], head_addr[p][0]} == 2'(b));
      end
    end
  end

  assign wr.wr_ready = ready;

  // Round-robin: the candidate with the smallest distance from rr_ptr[b]
  // (modulo PORT_NUM) wins; the pointer moves to just past the winner.
  always_comb begin
    gnt      = '0;
    bank_hit = '0;
    rr_nxt   = rr_ptr;
    win_row  = '0;
    win_data = '0;
    d        = 0;
    best_d   = 0;
    best_p   = 0;
    nxt      = 0;
    for (int b = 0; b < 4; b++) begin
      best_d = PORT_NUM;
      best_p = 0;
      for (int p = 0; p < PORT_NUM; p++) begin
        d = p - int'(rr_ptr[b]);
        if (d < 0) d = d + PORT_NUM;
        if (cand[b][p] && (d < best_d)) begin
          best_d = d;
          best_p = p;
        end
      end
      if (best_d < PORT_NUM) begin
        bank_hit[b] = 1'b1;
        nxt         = (best_p + 1 == PORT_NUM) ? 0 : best_p + 1;
        rr_nxt[b]   = PTR_W'(nxt);
        for (int p = 0; p < PORT_NUM; p++) begin
          if (p == best_p) begin
            gnt[b][p]   = 1'b1;
            win_row[b]  = head_addr[p][ADDR_WIDTH-2:1];
            win_data[b] = head_data[p];
          end
        end
      end
    end
  end

  // A head targets exactly one bank, so a port pops at most once per cycle.
  always_comb begin
    pop = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int b = 0; b < 4; b++) begin
        pop[p] = pop[p] | gnt[b][p];
      end
    end
  end

  always_comb begin
    busy = |bank_we;
    for (int p = 0; p < PORT_NUM; p++) begin
      busy = busy | (cnt[p] != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUM; p++) begin
      if (push[p]) begin
        mem_addr[p][wr_ptr[p]] <= wr.wr_addr[p];
        mem_data[p][wr_ptr[p]] <= wr.wr_data[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      rr_ptr     <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      bank_src   <= '0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        rd_ptr[p] <= rd_ptr[p] ^ pop[p];
        wr_ptr[p] <= wr_ptr[p] ^ push[p];
        if (push[p] && !pop[p]) cnt[p] <= cnt[p] + 2'd1;
        else if (pop[p] && !push[p]) cnt[p] <= cnt[p] - 2'd1;
      end
      rr_ptr   <= rr_nxt;
      bank_we  <= bank_hit;
      bank_src <= gnt;
      for (int b = 0; b < 4; b++) begin
        if (bank_hit[b]) begin
          bank_addr[b]  <= win_row[b];
          bank_wdata[b] <= win_data[b];
        end
      end
    end
  end
endmodule

// File: tb/tb_vrf_write_scheduler.sv
module tb_vrf_write_scheduler;
  localparam int PN = 2;
  localparam int AW = 6;
  localparam int RW = 4;
  localparam int DW = 128;
  localparam int EW = PN + RW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vrf_write_scheduler_if #(.PORT_NUM(PN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_if ();

  logic [3:0]          bank_we;
  logic [3:0][RW-1:0]  bank_addr;
  logic [3:0][DW-1:0]  bank_wdata;
  logic [3:0][PN-1:0]  bank_src;
  logic                busy;

  vrf_write_scheduler #(
    .PORT_NUM(PN), .ADDR_WIDTH(AW), .ROW_WIDTH(RW), .DATA_WIDTH(DW), .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_if),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_src   (bank_src),
    .busy       (busy)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0]    exp_q [4][$];
  logic [AW+DW-1:0] req_q [PN][$];
  logic [PN-1:0]    rdy_prev;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_q[p].push_back({a, d});
  endtask

  task automatic expect_wr(input int b, input logic [PN-1:0] src, input logic [RW-1:0] row,
                           input logic [DW-1:0] d);
    exp_q[b].push_back({src, row, d});
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic yhi, input logic [RW-1:0] row, input logic x);
    return {yhi, row, x};
  endfunction

  // Presents queued requests on the falling edge and holds them until a
  // rising edge sees wr_valid && wr_ready.
  initial begin
    wr_if.wr_valid = '0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    rdy_prev       = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < PN; p++) begin
        if (rst_n && wr_if.wr_valid[p] && rdy_prev[p] && (req_q[p].size() > 0))
          void'(req_q[p].pop_front());
        if (rst_n && (req_q[p].size() > 0)) begin
          {wr_if.wr_addr[p], wr_if.wr_data[p]} = req_q[p][0];
          wr_if.wr_valid[p] = 1'b1;
        end else begin
          wr_if.wr_valid[p] = 1'b0;
        end
        rdy_prev[p] = wr_if.wr_ready[p];
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int b = 0; b < 4; b++) begin
          if (bank_we[b]) begin
            if (exp_q[b].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL bank%0d_unexpected_write: got src=%0h row=%0h data=%0h expected no write",
                       b, bank_src[b], bank_addr[b], bank_wdata[b]);
            end else begin
              e = exp_q[b].pop_front();
              check($sformatf("bank%0d_write", b), {bank_src[b], bank_addr[b], bank_wdata[b]}, e);
            end
          end else begin
            check($sformatf("bank%0d_idle_src", b), bank_src[b], '0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_bank_we", bank_we, 4'b0000);
    check("rst_wr_ready", wr_if.wr_ready, 2'b11);
    check("rst_busy", busy, 1'b0);
    check("rst_bank_src", bank_src, '0);
    check("rst_bank_addr", bank_addr, '0);
    check("rst_bank_wdata0", bank_wdata[0], '0);
    rst_n = 1'b1;
    tick();

    // Single write: addr 0_0011_1 -> bank 1, row 3.
    send(0, 6'b000111, {16{8'hA5}});
    expect_wr(1, 2'b01, 4'd3, {16{8'hA5}});
    tick();
    check("t1_we_c1", bank_we, 4'b0000);
    check("t1_busy_c1", busy, 1'b1);
    tick();
    check("t1_we_c2", bank_we, 4'b0010);
    check("t1_addr", bank_addr[1], 4'd3);
    check("t1_src", bank_src[1], 2'b01);
    check("t1_busy_c2", busy, 1'b1);
    tick();
    check("t1_we_c3", bank_we, 4'b0000);
    check("t1_busy_c3", busy, 1'b0);

    // Parallel banks: port0 -> bank 0, port1 -> bank 3, eight each.
    for (int i = 0; i < 8; i++) begin
      send(0, 6'h00, DW'(32'h200 + i));
      send(1, 6'h21, DW'(32'h280 + i));
      expect_wr(0, 2'b01, 4'd0, DW'(32'h200 + i));
      expect_wr(3, 2'b10, 4'd0, DW'(32'h280 + i));
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t2_ready_c%0d", i), wr_if.wr_ready, 2'b11);
      if (i >= 2 && i <= 9) check($sformatf("t2_we_c%0d", i), bank_we, 4'b1001);
    end
    check("t2_we_end", bank_we, 4'b0000);
    check("t2_busy_end", busy, 1'b0);

    // Same-bank conflict on bank 0. rr_ptr[0] is 1 after the port0 grants
    // above, so port1 wins first and the two ports then alternate.
    for (int i = 0; i < 4; i++) begin
      send(0, mk_addr(1'b0, RW'(1 + i), 1'b0), DW'(32'h300 + i));
      send(1, mk_addr(1'b0, RW'(9 + i), 1'b0), DW'(32'h310 + i));
      expect_wr(0, 2'b10, RW'(9 + i), DW'(32'h310 + i));
      expect_wr(0, 2'b01, RW'(1 + i), DW'(32'h300 + i));
    end
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) check("t3_ready_c2", wr_if.wr_ready, 2'b10);
      if (i == 3) check("t3_ready_c3", wr_if.wr_ready, 2'b01);
      if (i >= 2 && i <= 9) check($sformatf("t3_we_c%0d", i), bank_we, 4'b0001);
    end
    check("t3_we_end", bank_we, 4'b0000);
    check("t3_busy_end", busy, 1'b0);

    // Backpressure on bank 2: a port0 grant first moves rr_ptr[2] to 1, then
    // three requests per port; port0's third request waits for a pop.
    send(0, mk_addr(1'b1, 4'd5, 1'b0), DW'(32'h400));
    expect_wr(2, 2'b01, 4'd5, DW'(32'h400));
    tick();
    tick();
    check("t4_pre_we", bank_we, 4'b0100);
    tick();
    for (int i = 0; i < 3; i++) begin
      send(0, mk_addr(1'b1, RW'(6 + i), 1'b0), DW'(32'h410 + i));
      send(1, mk_addr(1'b1, RW'(12 + i), 1'b0), DW'(32'h420 + i));
      expect_wr(2, 2'b10, RW'(12 + i), DW'(32'h420 + i));
      expect_wr(2, 2'b01, RW'(6 + i), DW'(32'h410 + i));
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) check("t4_ready_full", wr_if.wr_ready, 2'b10);
      if (i == 3) check("t4_ready_after_pop", wr_if.wr_ready, 2'b01);
      if (i >= 2 && i <= 7) check($sformatf("t4_we_c%0d", i), bank_we, 4'b0100);
    end
    check("t4_busy_end", busy, 1'b0);

    // Round-robin on bank 0: after a port0 grant, a simultaneous pair goes
    // port1 then port0.
    send(0, mk_addr(1'b0, 4'd7, 1'b0), DW'(32'h500));
    expect_wr(0, 2'b01, 4'd7, DW'(32'h500));
    tick();
    tick();
    tick();
    send(0, mk_addr(1'b0, 4'd8, 1'b0), DW'(32'h510));
    send(1, mk_addr(1'b0, 4'd9, 1'b0), DW'(32'h520));
    expect_wr(0, 2'b10, 4'd9, DW'(32'h520));
    expect_wr(0, 2'b01, 4'd8, DW'(32'h510));
    tick();
    tick();
    check("t5_first_src", bank_src[0], 2'b10);
    tick();
    check("t5_second_src", bank_src[0], 2'b01);
    tick();
    check("t5_busy_end", busy, 1'b0);

    // Async reset while requests are queued and a bank write is live.
    for (int i = 0; i < 4; i++) begin
      send(0, mk_addr(1'b0, RW'(i), 1'b1), DW'(32'h700 + i));
      send(1, mk_addr(1'b0, RW'(4 + i), 1'b1), DW'(32'h780 + i));
    end
    tick();
    tick();
    check("t6_we_live", bank_we, 4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_we_async", bank_we, 4'b0000);
    check("t6_src_async", bank_src[1], 2'b00);
    check("t6_busy_async", busy, 1'b0);
    check("t6_ready_async", wr_if.wr_ready, 2'b11);
    req_q[0].delete();
    req_q[1].delete();
    tick();
    tick();
    rst_n = 1'b1;
    check("t6_ready_rel", wr_if.wr_ready, 2'b11);
    check("t6_busy_rel", busy, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t6_no_stale_c%0d", i), bank_we, 4'b0000);
    end

    // Normal operation resumes after reset.
    send(1, mk_addr(1'b0, 4'd2, 1'b1), DW'(32'h600));
    expect_wr(1, 2'b10, 4'd2, DW'(32'h600));
    tick();
    tick();
    check("t7_we", bank_we, 4'b0010);
    tick();
    tick();

    for (int b = 0; b < 4; b++) check($sformatf("bank%0d_exp_left", b), exp_q[b].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
